// File: rtl/p23_divider_unit.sv
// RV32M divide/remainder unit: radix-2 restoring divider, one quotient bit per cycle,
// single-cycle divide-by-zero and signed-overflow paths. Optional macro: DIV_EARLY_OUT_EN.
module p23_divider_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_valid,
    input  logic [1:0]       DIVop,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] div_result,
    output logic             div_ready,
    output logic             div_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] v);
        return (~v) + ONE;
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic is_signed);
        if (is_signed && v[WIDTH-1]) begin
            return neg_val(v);
        end else begin
            return v;
        end
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [1:0]         op_q, op_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    logic               op_signed_s;
    logic [WIDTH-1:0]   abs_a_s, abs_b_s;
    logic               div_zero_s, ovf_s, early_s;
    logic [WIDTH:0]     shifted_s, trial_s;

    assign op_signed_s = ~DIVop[0];
    assign abs_a_s     = abs_val(dividend, op_signed_s);
    assign abs_b_s     = abs_val(divisor, op_signed_s);
    assign div_zero_s  = (divisor == ZERO);
    assign ovf_s       = op_signed_s && (dividend == S_MIN) && (divisor == ONES);
`ifdef DIV_EARLY_OUT_EN
    assign early_s     = (abs_b_s > abs_a_s);
`else
    assign early_s     = 1'b0;
`endif

    assign shifted_s = {rem_q, quo_q[WIDTH-1]};
    assign trial_s   = shifted_s - {1'b0, dvs_q};

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // ready_q marks the handshake cycle where the initiator still holds div_valid.
                if (div_valid && !ready_q) begin
                    op_d      = DIVop;
                    dvs_d     = abs_b_s;
                    neg_quo_d = 1'b0;
                    neg_rem_d = 1'b0;
                    if (div_zero_s) begin
                        quo_d   = ONES;
                        rem_d   = dividend;
                        state_d = DONE;
                    end else if (ovf_s) begin
                        quo_d   = S_MIN;
                        rem_d   = ZERO;
                        state_d = DONE;
                    end else if (early_s) begin
                        quo_d   = ZERO;
                        rem_d   = dividend;
                        state_d = DONE;
                    end else begin
                        quo_d     = abs_a_s;
                        rem_d     = ZERO;
                        cnt_d     = CNT_W'(WIDTH);
                        neg_quo_d = op_signed_s && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_rem_d = op_signed_s && dividend[WIDTH-1];
                        state_d   = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (!trial_s[WIDTH]) begin
                    rem_d = trial_s[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted_s[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                if (op_q[1]) begin
                    result_d = neg_rem_q ? neg_val(rem_q) : rem_q;
                end else begin
                    result_d = neg_quo_q ? neg_val(quo_q) : quo_q;
                end
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            quo_q     <= ZERO;
            rem_q     <= ZERO;
            dvs_q     <= ZERO;
            op_q      <= 2'b00;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= ZERO;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign div_result = result_q;
    assign div_ready  = ready_q;
    assign div_busy   = busy_q;

endmodule

// File: tb/tb_p23_divider_unit.sv
// Self-checking bench for p23_divider_unit: directed vector table, reset-abort sequence,
// and randomized operations against an arithmetic reference model.
module tb_p23_divider_unit;

    logic        clk;
    logic        resetn;
    logic        div_valid;
    logic [1:0]  DIVop;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] div_result;
    logic        div_ready;
    logic        div_busy;

    int total;
    int bad;

`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 33;
`endif

    p23_divider_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_valid  (div_valid),
        .DIVop      (DIVop),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_result (div_result),
        .div_ready  (div_ready),
        .div_busy   (div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: 64-bit integer arithmetic with the RISC-V special cases.
    function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = op[0] ? longint'({32'd0, a}) : longint'($signed(a));
        sb = op[0] ? longint'({32'd0, b}) : longint'($signed(b));
        if (b == 32'd0) begin
            q = -64'sd1;
            r = sa;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return op[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = op[0] ? longint'({32'd0, a}) : longint'($signed(a));
        sb = op[0] ? longint'({32'd0, b}) : longint'($signed(b));
        if (sa < 0) sa = -sa;
        if (sb < 0) sb = -sb;
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        if (sb > sa) return EARLY_LAT;
        return 33;
    endfunction

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        logic [31:0] res;
        lat = -1;
        res = 32'd0;
        @(negedge clk);
        DIVop     = op;
        dividend  = a;
        divisor   = b;
        div_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 1 && exp_lat > 1) chk({name, " busy"}, {31'd0, div_busy}, 32'd1);
            if (k == 3) begin
                dividend = $urandom;
                divisor  = $urandom;
            end
            if (div_ready) begin
                lat = k;
                res = div_result;
                break;
            end
        end
        if (lat < 0) begin
            total++;
            bad++;
            $display("FAIL %s timeout: no div_ready within 40 cycles, expected at %0d", name, exp_lat);
        end else begin
            chk({name, " result"}, res, exp);
            chk({name, " latency"}, lat, exp_lat);
            @(posedge clk);
            #1;
            chk({name, " pulse"}, {30'd0, div_ready, div_busy}, 32'd0);
            chk({name, " hold"}, div_result, exp);
        end
        div_valid = 1'b0;
    endtask

    vec_t tbl[13];

    initial begin
        total     = 0;
        bad       = 0;
        resetn    = 1'b0;
        div_valid = 1'b0;
        DIVop     = 2'b00;
        dividend  = 32'd0;
        divisor   = 32'd0;

        tbl[0]  = '{"DIV 100/7",      2'b00, 32'd100,        32'd7,          32'd14,         33};
        tbl[1]  = '{"REM 100/7",      2'b10, 32'd100,        32'd7,          32'd2,          33};
        tbl[2]  = '{"DIV -100/7",     2'b00, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  33};
        tbl[3]  = '{"REM -100/7",     2'b10, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  33};
        tbl[4]  = '{"REM 100/-7",     2'b10, 32'd100,        32'hFFFF_FFF9,  32'd2,          33};
        tbl[5]  = '{"DIVU max/2",     2'b01, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  33};
        tbl[6]  = '{"REMU max/2",     2'b11, 32'hFFFF_FFFF,  32'd2,          32'd1,          33};
        tbl[7]  = '{"DIV 5/0",        2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        tbl[8]  = '{"REMU 5/0",       2'b11, 32'd5,          32'd0,          32'd5,          1};
        tbl[9]  = '{"DIV ovf",        2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        tbl[10] = '{"REM ovf",        2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        tbl[11] = '{"DIVU 3/10",      2'b01, 32'd3,          32'd10,         32'd0,          EARLY_LAT};
        tbl[12] = '{"REMU 3/10",      2'b11, 32'd3,          32'd10,         32'd3,          EARLY_LAT};

        repeat (3) @(posedge clk);
        #1;
        chk("reset result", div_result, 32'd0);
        chk("reset flags", {30'd0, div_ready, div_busy}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);
        end

        // Reset in the middle of a long division aborts it without a ready strobe.
        @(negedge clk);
        DIVop     = 2'b00;
        dividend  = 32'd100;
        divisor   = 32'd7;
        div_valid = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        chk("mid busy", {31'd0, div_busy}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("abort flags", {30'd0, div_ready, div_busy}, 32'd0);
        chk("abort result", div_result, 32'd0);
        div_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (div_ready || div_busy) begin
                chk("abort idle", {30'd0, div_ready, div_busy}, 32'd0);
                break;
            end
        end
        run_op("DIV 9/3 after reset", 2'b00, 32'd9, 32'd3, 32'd3, 33);

        for (int n = 0; n < 30; n++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: a = 32'($urandom_range(0, 50));
                4: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            run_op($sformatf("rand%0d op%0d %h/%h", n, op, a, b), op, a, b,
                   model_res(op, a, b), model_lat(op, a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
